// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and geometry helpers for the set-associative
//                cache controller: controller state encoding, tag-entry
//                record and address-field width functions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_COMPARE_TAG = 2'd1,
        ST_WRITE_BACK  = 2'd2,
        ST_ALLOCATE    = 2'd3
    } state_t;

    // Tag field of the entry record is sized for the widest supported tag;
    // narrower geometries zero-extend into it.
    localparam int c_tag_max_w = 64;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [c_tag_max_w-1:0] tag;
    } tag_entry_t;

    function automatic int byte_off_w(input int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int word_off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int word_w,
                                 input int words, input int sets);
        return addr_w - byte_off_w(word_w) - word_off_w(words) - index_w(sets);
    endfunction

    // Way-index width; a single way still needs a 1-bit index signal
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // PLRU bits per set; a single way keeps one dummy bit
    function automatic int plru_w(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree.sv
`default_nettype none
// ============================================================================
//  Module      : plru_tree
//  Description : Combinational tree pseudo-LRU for one set. Produces the
//                victim way from the current bits and the next bits after an
//                access to a given way.
//  Ports       : plru_bits  - current tree bits of the set
//                access_way - way being accessed
//                victim_way - way the tree currently points at
//                next_bits  - tree bits after the access
//  Revision    : 1.0 - initial release
// ============================================================================
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [plru_w(WAYS)-1:0] plru_bits,
    input  logic [way_w(WAYS)-1:0]  access_way,
    output logic [way_w(WAYS)-1:0]  victim_way,
    output logic [plru_w(WAYS)-1:0] next_bits
);

    generate
        if (WAYS == 1) begin : g_single
            logic w_unused_way;
            assign w_unused_way = ^access_way;
            assign victim_way   = '0;
            assign next_bits    = plru_bits;
        end else begin : g_tree
            localparam int c_levels = $clog2(WAYS);

            // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2
            // (right). A bit value of 1 points the victim search right.
            always_comb begin
                int node;
                node       = 0;
                victim_way = '0;
                for (int l = 0; l < c_levels; l++) begin
                    victim_way[c_levels-1-l] = plru_bits[node];
                    node = 2 * node + 1 + int'(plru_bits[node]);
                end
                // Every node on the accessed path points away from it
                next_bits = plru_bits;
                node      = 0;
                for (int l = 0; l < c_levels; l++) begin
                    next_bits[node] = ~access_way[c_levels-1-l];
                    node = 2 * node + 1 + int'(access_way[c_levels-1-l]);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/assoc_cache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : assoc_cache_controller
//  Description : N-way set-associative, write-back, write-allocate cache
//                controller with tree pseudo-LRU replacement, between a
//                word-wide CPU port and a line-wide memory port.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                cpu_req_valid/rw/addr/datain, cache_ready
//                                           - CPU request handshake
//                cpu_resp_valid, cpu_req_dataout
//                                           - one-cycle response + read data
//                mem_req_valid/rw/addr/dataout, mem_req_ready
//                                           - line write-back / fill request
//                mem_resp_valid, mem_req_datain
//                                           - fill line return
//  Revision    : 1.0 - initial release
// ============================================================================
module assoc_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int SETS   = 1024,
    parameter int WAYS   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_rw,
    input  logic [ADDR_W-1:0]       cpu_req_addr,
    input  logic [WORD_W-1:0]       cpu_req_datain,
    output logic                    cache_ready,
    output logic                    cpu_resp_valid,
    output logic [WORD_W-1:0]       cpu_req_dataout,
    output logic                    mem_req_valid,
    output logic                    mem_req_rw,
    output logic [ADDR_W-1:0]       mem_req_addr,
    output logic [WORDS*WORD_W-1:0] mem_req_dataout,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [WORDS*WORD_W-1:0] mem_req_datain
);

    localparam int c_boff_w = byte_off_w(WORD_W);
    localparam int c_woff_w = word_off_w(WORDS);
    localparam int c_off_w  = c_boff_w + c_woff_w;
    localparam int c_idx_w  = index_w(SETS);
    localparam int c_tag_w  = tag_w(ADDR_W, WORD_W, WORDS, SETS);
    localparam int c_way_w  = way_w(WAYS);
    localparam int c_plru_w = plru_w(WAYS);
    localparam int c_line_w = WORDS * WORD_W;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];
    logic [c_plru_w-1:0] r_plru  [SETS];
    logic [c_tag_w-1:0]  r_tag   [SETS][WAYS];
    logic [c_line_w-1:0] r_data  [SETS][WAYS];

    // Latched request and controller state
    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [WORD_W-1:0]   r_wdata;
    logic [c_way_w-1:0]  r_victim;
    logic                r_fill_sent;

    // ------------------------------------------------------------------
    // Address decode of the latched request
    // ------------------------------------------------------------------
    logic [c_woff_w-1:0] w_woff;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;

    assign w_woff = r_addr[c_boff_w +: c_woff_w];
    assign w_idx  = r_addr[c_off_w +: c_idx_w];
    assign w_tag  = r_addr[ADDR_W-1 -: c_tag_w];

    generate
        if (c_boff_w > 0) begin : g_boff_sink
            logic w_unused_boff;
            assign w_unused_boff = ^r_addr[c_boff_w-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tag lookup, hit detection, victim selection
    // ------------------------------------------------------------------
    tag_entry_t          w_entry [WAYS];
    logic                w_hit;
    logic [c_way_w-1:0]  w_hit_way;
    logic                w_inv_found;
    logic [c_way_w-1:0]  w_inv_way;
    logic [c_way_w-1:0]  w_plru_victim;
    logic [c_way_w-1:0]  w_victim;
    logic [c_plru_w-1:0] w_plru_next;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_entry
            assign w_entry[g].valid = r_valid[w_idx][g];
            assign w_entry[g].dirty = r_dirty[w_idx][g];
            assign w_entry[g].tag   = c_tag_max_w'(r_tag[w_idx][g]);
        end
    endgenerate

    // Descending scan so the lowest-index match / invalid way wins
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_entry[w].valid && (w_entry[w].tag == c_tag_max_w'(w_tag))) begin
                w_hit     = 1'b1;
                w_hit_way = c_way_w'(w);
            end
            if (!w_entry[w].valid) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_way_w'(w);
            end
        end
    end

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .plru_bits  (r_plru[w_idx]),
        .access_way (w_hit_way),
        .victim_way (w_plru_victim),
        .next_bits  (w_plru_next)
    );

    // Filling an empty way always beats evicting a live one
    assign w_victim = w_inv_found ? w_inv_way : w_plru_victim;

    // ------------------------------------------------------------------
    // Line data paths
    // ------------------------------------------------------------------
    logic [c_line_w-1:0] w_hit_line;
    logic [WORD_W-1:0]   w_hit_word;
    logic [c_line_w-1:0] w_merged;
    logic [c_line_w-1:0] w_vict_line;

    assign w_hit_line  = r_data[w_idx][w_hit_way];
    assign w_hit_word  = w_hit_line[w_woff*WORD_W +: WORD_W];
    assign w_vict_line = r_data[w_idx][w_victim];

    always_comb begin
        w_merged = w_hit_line;
        w_merged[w_woff*WORD_W +: WORD_W] = r_wdata;
    end

    // Fill data is taken when it arrives for an issued fill: either after
    // the request handshake, or in the same cycle as that handshake.
    logic w_fill_take;
    assign w_fill_take = (r_state == ST_ALLOCATE) && mem_resp_valid &&
                         (r_fill_sent || (mem_req_valid && mem_req_ready));

    logic                w_line_we;
    logic [c_way_w-1:0]  w_line_way;
    logic [c_line_w-1:0] w_line_wdata;

    assign w_line_we    = ((r_state == ST_COMPARE_TAG) && w_hit && r_rw) || w_fill_take;
    assign w_line_way   = w_fill_take ? r_victim : w_hit_way;
    assign w_line_wdata = w_fill_take ? mem_req_datain : w_merged;

    // Tag and line arrays carry no reset; valid bits guard their contents
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_data[w_idx][w_line_way] <= w_line_wdata;
        end
        if (w_fill_take) begin
            r_tag[w_idx][r_victim] <= w_tag;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs and per-set metadata
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_rw            <= 1'b0;
            r_wdata         <= '0;
            r_victim        <= '0;
            r_fill_sent     <= 1'b0;
            cache_ready     <= 1'b0;
            cpu_resp_valid  <= 1'b0;
            cpu_req_dataout <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_rw      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_dataout <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            cpu_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    cache_ready <= 1'b1;
                    if (cache_ready && cpu_req_valid) begin
                        r_addr      <= cpu_req_addr;
                        r_rw        <= cpu_req_rw;
                        r_wdata     <= cpu_req_datain;
                        cache_ready <= 1'b0;
                        r_state     <= ST_COMPARE_TAG;
                    end
                end

                ST_COMPARE_TAG: begin
                    if (w_hit) begin
                        if (r_rw) begin
                            r_dirty[w_idx][w_hit_way] <= 1'b1;
                        end else begin
                            cpu_req_dataout <= w_hit_word;
                        end
                        r_plru[w_idx]  <= w_plru_next;
                        cpu_resp_valid <= 1'b1;
                        cache_ready    <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_victim      <= w_victim;
                        mem_req_valid <= 1'b1;
                        if (w_entry[w_victim].valid && w_entry[w_victim].dirty) begin
                            mem_req_rw      <= 1'b1;
                            mem_req_addr    <= {r_tag[w_idx][w_victim], w_idx, {c_off_w{1'b0}}};
                            mem_req_dataout <= w_vict_line;
                            r_state         <= ST_WRITE_BACK;
                        end else begin
                            mem_req_rw   <= 1'b0;
                            mem_req_addr <= {w_tag, w_idx, {c_off_w{1'b0}}};
                            r_fill_sent  <= 1'b0;
                            r_state      <= ST_ALLOCATE;
                        end
                    end
                end

                ST_WRITE_BACK: begin
                    if (mem_req_ready) begin
                        mem_req_valid              <= 1'b0;
                        r_dirty[w_idx][r_victim]   <= 1'b0;
                        r_fill_sent                <= 1'b0;
                        r_state                    <= ST_ALLOCATE;
                    end
                end

                ST_ALLOCATE: begin
                    if (!r_fill_sent) begin
                        if (!mem_req_valid) begin
                            // Entered from a write-back: issue the fill now
                            mem_req_valid <= 1'b1;
                            mem_req_rw    <= 1'b0;
                            mem_req_addr  <= {w_tag, w_idx, {c_off_w{1'b0}}};
                        end else if (mem_req_ready) begin
                            mem_req_valid <= 1'b0;
                            r_fill_sent   <= 1'b1;
                        end
                    end
                    if (w_fill_take) begin
                        r_valid[w_idx][r_victim] <= 1'b1;
                        r_dirty[w_idx][r_victim] <= 1'b0;
                        r_fill_sent              <= 1'b0;
                        r_state                  <= ST_COMPARE_TAG;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_assoc_cache_controller
//  Description : Self-checking bench for assoc_cache_controller (2 ways,
//                16 sets, 4-word lines). A reference model tracks each set
//                as an LRU-ordered list of resident tags, a CPU-visible word
//                image and a backing-memory image; the bench also acts as
//                the main memory with random handshake delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_cache_controller;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int WORDS  = 4;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;
    localparam int LINE_W = WORDS * WORD_W;

    logic              clk;
    logic              rst_n;
    logic              cpu_req_valid;
    logic              cpu_req_rw;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [WORD_W-1:0] cpu_req_datain;
    logic              cache_ready;
    logic              cpu_resp_valid;
    logic [WORD_W-1:0] cpu_req_dataout;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_dataout;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_req_datain;

    assoc_cache_controller #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .SETS   (SETS),
        .WAYS   (WAYS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cache_ready     (cache_ready),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_req_dataout (cpu_req_dataout),
        .mem_req_valid   (mem_req_valid),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_req_datain  (mem_req_datain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int unsigned tag;
        bit          dirty;
    } ent_t;

    ent_t        res [SETS][$];          // front = most recently used
    logic [31:0] view_mem [int unsigned]; // what the CPU must read
    logic [31:0] back_mem [int unsigned]; // what main memory holds

    function automatic logic [31:0] init_word(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] rd_back(input int unsigned a);
        return back_mem.exists(a) ? back_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rd_view(input int unsigned a);
        return view_mem.exists(a) ? view_mem[a] : rd_back(a);
    endfunction

    function automatic logic [LINE_W-1:0] back_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < WORDS; w++) l[w*WORD_W +: WORD_W] = rd_back(la + 4 * w);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] view_line(input int unsigned la);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < WORDS; w++) l[w*WORD_W +: WORD_W] = rd_view(la + 4 * w);
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) res[s].delete();
        view_mem.delete();
    endtask

    // Observations of the most recent access, for directed checks
    bit          last_hit;
    int unsigned last_wb_addr;
    logic [LINE_W-1:0] last_wb_line;

    // ------------------------------------------------------------------
    // One CPU access, with the bench serving memory traffic.
    // hold_force >= 0 fixes the number of ready-low cycles per memory request.
    // ------------------------------------------------------------------
    task automatic do_access(input bit rw, input logic [31:0] addr,
                             input logic [31:0] wdata, input int hold_force);
        int unsigned idx, tag, wa, fill_addr, wb_addr;
        int          pos, cyc, n, resp_cyc, n_fill, n_wb, hold, lat;
        bit          exp_hit, exp_wb, got, seen, pend, s_rw;
        logic [31:0] exp_rdata;
        logic [LINE_W-1:0] wb_line, s_data;
        logic [31:0] s_addr;
        ent_t        e, v;

        // Model prediction
        idx       = (addr >> 4) & (SETS - 1);
        tag       = addr >> 8;
        wa        = addr & ~32'h3;
        fill_addr = addr & ~32'hF;
        pos       = -1;
        for (int i = 0; i < res[idx].size(); i++) if (res[idx][i].tag == tag) pos = i;
        exp_hit = (pos >= 0);
        exp_wb  = 1'b0;
        wb_addr = 0;
        wb_line = '0;
        if (exp_hit) begin
            e = res[idx][pos];
            res[idx].delete(pos);
        end else begin
            if (res[idx].size() == WAYS) begin
                v = res[idx].pop_back();
                if (v.dirty) begin
                    exp_wb  = 1'b1;
                    wb_addr = (v.tag << 8) | (idx << 4);
                    wb_line = view_line(wb_addr);
                end
            end
            e.tag   = tag;
            e.dirty = 1'b0;
        end
        if (rw) e.dirty = 1'b1;
        res[idx].push_front(e);
        exp_rdata = rd_view(wa);

        // Present the request
        n = 0;
        while (!cache_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_wait", cache_ready, 1'b1);
        cpu_req_valid  = 1'b1;
        cpu_req_rw     = rw;
        cpu_req_addr   = addr;
        cpu_req_datain = wdata;
        @(negedge clk);
        check_eq("busy_after_accept", cache_ready, 1'b0);

        cyc = 1; got = 0; seen = 0; pend = 0; n_fill = 0; n_wb = 0;
        resp_cyc = 0; hold = 0; lat = 0; s_rw = 0; s_addr = '0; s_data = '0;
        while (!got && cyc < 300) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            // Garbage request while busy must be ignored
            cpu_req_valid  = (cyc == 1);
            cpu_req_rw     = 1'($urandom);
            cpu_req_addr   = $urandom;
            cpu_req_datain = $urandom;
            if (cpu_resp_valid) begin
                got      = 1;
                resp_cyc = cyc;
                if (!rw) check_eq("read_data", cpu_req_dataout, exp_rdata);
                check_eq("ready_with_resp", cache_ready, 1'b1);
            end else if (pend) begin
                if (lat == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_req_datain = back_line(fill_addr);
                    pend = 0;
                end else begin
                    lat--;
                end
            end else if (mem_req_valid) begin
                if (!seen) begin
                    seen   = 1;
                    s_addr = mem_req_addr;
                    s_rw   = mem_req_rw;
                    s_data = mem_req_dataout;
                    hold   = (hold_force >= 0) ? hold_force : int'($urandom_range(0, 2));
                    check_eq("mem_rw", mem_req_rw, (exp_wb && n_wb == 0));
                    check_eq("mem_addr", mem_req_addr,
                             (exp_wb && n_wb == 0) ? wb_addr : fill_addr);
                end else begin
                    check_eq("mem_addr_stable", mem_req_addr, s_addr);
                    check_eq("mem_rw_stable", mem_req_rw, s_rw);
                    if (s_rw) check_eq("mem_data_stable", mem_req_dataout, s_data);
                end
                if (hold == 0) begin
                    mem_req_ready = 1'b1;
                    seen = 0;
                    if (mem_req_rw) begin
                        n_wb++;
                        last_wb_addr = mem_req_addr;
                        last_wb_line = mem_req_dataout;
                        check_eq("wb_data", mem_req_dataout, wb_line);
                        for (int w = 0; w < WORDS; w++)
                            back_mem[mem_req_addr + 4 * w] = mem_req_dataout[w*WORD_W +: WORD_W];
                    end else begin
                        n_fill++;
                        lat = int'($urandom_range(0, 3));
                        if (lat == 0) begin
                            mem_resp_valid = 1'b1;
                            mem_req_datain = back_line(fill_addr);
                        end else begin
                            pend = 1;
                            lat--;
                        end
                    end
                end else begin
                    hold--;
                end
            end else if (cyc == 1) begin
                // Stray fill data with no fill outstanding
                mem_resp_valid = 1'b1;
                mem_req_datain = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!got) begin
                @(negedge clk);
                cyc++;
            end
        end
        cpu_req_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;

        check_eq("resp_seen", got, 1'b1);
        last_hit = (resp_cyc == 2) && (n_fill == 0);
        if (exp_hit) begin
            check_eq("hit_latency", resp_cyc, 2);
            check_eq("hit_no_mem", n_fill + n_wb, 0);
        end else begin
            check_eq("miss_fills", n_fill, 1);
            check_eq("miss_wbs", n_wb, exp_wb);
        end
        @(negedge clk);
        check_eq("resp_pulse", cpu_resp_valid, 1'b0);
        if (rw) view_mem[wa] = wdata;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ready"}, cache_ready, 1'b0);
        check_eq({pfx, "_resp"}, cpu_resp_valid, 1'b0);
        check_eq({pfx, "_rdata"}, cpu_req_dataout, '0);
        check_eq({pfx, "_mvalid"}, mem_req_valid, 1'b0);
        check_eq({pfx, "_mrw"}, mem_req_rw, 1'b0);
        check_eq({pfx, "_maddr"}, mem_req_addr, '0);
        check_eq({pfx, "_mdata"}, mem_req_dataout, '0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        logic [31:0] a;
        rst_n          = 1'b0;
        cpu_req_valid  = 1'b0;
        cpu_req_rw     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_datain = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_req_datain = '0;
        last_hit       = 0;
        last_wb_addr   = 0;
        last_wb_line   = '0;

        back_mem[32'h10] = 32'hDEAD_BEEF;
        back_mem[32'h14] = 32'h4444_4444;
        back_mem[32'h18] = 32'h4444_4444;
        back_mem[32'h1C] = 32'h4444_4444;

        // Reset and ready timing
        #1;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_eq("ready_at_release", cache_ready, 1'b0);
        @(negedge clk);
        check_eq("ready_after_release", cache_ready, 1'b1);

        // Cold read, then hit
        do_access(0, 32'h10, 0, -1);
        check_eq("cold_read_value", cpu_req_dataout, 32'hDEAD_BEEF);
        do_access(0, 32'h10, 0, -1);
        check_eq("repeat_is_hit", last_hit, 1'b1);

        // Word write merge
        do_access(1, 32'h14, 32'h1234_5678, -1);
        do_access(0, 32'h14, 0, -1);
        check_eq("merged_word", cpu_req_dataout, 32'h1234_5678);
        do_access(0, 32'h10, 0, -1);
        check_eq("neighbour_lo", cpu_req_dataout, 32'hDEAD_BEEF);
        do_access(0, 32'h18, 0, -1);
        check_eq("neighbour_hi", cpu_req_dataout, 32'h4444_4444);

        // Replacement in set 1: A, B, touch A, C evicts B
        do_access(0, 32'hA10, 0, -1);
        do_access(0, 32'hB10, 0, -1);
        do_access(0, 32'hA10, 0, -1);
        do_access(0, 32'hC10, 0, -1);
        do_access(0, 32'hA10, 0, -1);
        check_eq("plru_keeps_A", last_hit, 1'b1);
        do_access(0, 32'hB14, 0, -1);
        check_eq("plru_evicted_B", last_hit, 1'b0);

        // Dirty eviction in set 2 with a slow memory
        do_access(1, 32'hD20, 32'hCAFE_F00D, -1);
        do_access(0, 32'hE20, 0, -1);
        do_access(0, 32'hF20, 0, 5);
        check_eq("wb_old_tag_addr", last_wb_addr, 32'hD20);
        check_eq("wb_merged_word", last_wb_line[31:0], 32'hCAFE_F00D);
        do_access(0, 32'hD20, 0, -1);
        check_eq("refetch_written", cpu_req_dataout, 32'hCAFE_F00D);

        // Reset while a fill is outstanding
        n = 0;
        while (!cache_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cpu_req_valid = 1'b1;
        cpu_req_rw    = 1'b0;
        cpu_req_addr  = 32'h3030;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        n = 0;
        while (!(mem_req_valid && !mem_req_rw) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("fill_before_abort", mem_req_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_access(0, 32'h3030, 0, -1);
        check_eq("post_reset_miss", last_hit, 1'b0);

        // Randomised traffic over a few conflicting sets
        for (int k = 0; k < 200; k++) begin
            a = (32'($urandom_range(0, 4)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            do_access(1'($urandom_range(0, 1)), a, $urandom, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
